// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the 32-to-16-bit SRAM width bridge.
package sram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_LO  = 2'd1,
        ACC_HI  = 2'd2,
        RD_TAIL = 2'd3
    } bridge_state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // Processor word must be exactly two SRAM half-words wide.
    localparam int WIDTH_RATIO = 2;

    function automatic bit width_ratio_ok(input int data_w, input int sram_w);
        return data_w == WIDTH_RATIO * sram_w;
    endfunction

endpackage

// File: rtl/sram_width_bridge.sv
// Splits each 32-bit processor access into two 16-bit synchronous-SRAM accesses, low half first.
// Optional byte-enable support is built when SRAM_BRIDGE_BE_EN is defined.
module sram_width_bridge
    import sram_bridge_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int SRAM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_rd_en,
    input  logic                       req_wr_en,
    input  logic [SRAM_ADDR_WIDTH-2:0] req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wr_data,
`ifdef SRAM_BRIDGE_BE_EN
    input  logic [3:0]                 req_be,
`endif
    output logic                       busy,
    output logic                       wr_ack,
    output logic                       rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rd_data,
    output logic                       sram_ce_n,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic                       sram_ub_n,
    output logic                       sram_lb_n,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data
);

    localparam bit W_RATIO_OK = width_ratio_ok(DATA_WIDTH, SRAM_DATA_WIDTH);
    localparam int HALF_W     = W_RATIO_OK ? DATA_WIDTH / WIDTH_RATIO : SRAM_DATA_WIDTH;

    bridge_state_t                r_state;
    bridge_state_t                w_state_next;
    logic [SRAM_ADDR_WIDTH-2:0]   r_addr;
    logic [DATA_WIDTH-1:0]        r_wdata;
    logic                         r_is_wr;
    logic [HALF_W-1:0]            r_lo;
    logic [DATA_WIDTH-1:0]        r_rsp_data;
    logic                         r_wr_ack;
    logic                         r_rsp_valid;
    logic                         w_accept;
    logic                         w_active;
    logic                         w_half;
`ifdef SRAM_BRIDGE_BE_EN
    logic [3:0]                   r_be;
`endif

    assign w_accept = (r_state == IDLE) && (req_wr_en || req_rd_en);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_wr_en || req_rd_en) w_state_next = ACC_LO;
            ACC_LO:  w_state_next = ACC_HI;
            ACC_HI:  w_state_next = r_is_wr ? IDLE : RD_TAIL;
            RD_TAIL: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_wr     <= 1'b0;
            r_lo        <= '0;
            r_rsp_data  <= '0;
            r_wr_ack    <= 1'b0;
            r_rsp_valid <= 1'b0;
`ifdef SRAM_BRIDGE_BE_EN
            r_be        <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_wr_ack    <= (r_state == ACC_HI) && r_is_wr;
            r_rsp_valid <= (r_state == RD_TAIL);
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wr_data;
                r_is_wr <= req_wr_en;
`ifdef SRAM_BRIDGE_BE_EN
                r_be    <= req_be;
`endif
            end
            // SRAM data lags the address by one cycle: low half arrives during ACC_HI.
            if (r_state == ACC_HI && !r_is_wr) begin
                r_lo <= sram_rd_data;
            end
            if (r_state == RD_TAIL) begin
                r_rsp_data <= {sram_rd_data, r_lo};
            end
        end
    end

    // Gating with rst stops the SRAM from being touched on the edge that aborts an access.
    assign w_active = !rst && (r_state == ACC_LO || r_state == ACC_HI);
    assign w_half   = (r_state == ACC_HI) ? HALF_HI : HALF_LO;

    always_comb begin
        sram_ce_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_ub_n    = 1'b1;
        sram_lb_n    = 1'b1;
        sram_addr    = '0;
        sram_wr_data = '0;
        if (w_active) begin
            sram_ce_n = 1'b0;
            sram_addr = {r_addr, w_half};
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
            if (r_is_wr) begin
                sram_we_n    = 1'b0;
                sram_wr_data = (w_half == HALF_HI) ? r_wdata[DATA_WIDTH-1:HALF_W]
                                                   : r_wdata[HALF_W-1:0];
`ifdef SRAM_BRIDGE_BE_EN
                sram_lb_n = (w_half == HALF_HI) ? !r_be[2] : !r_be[0];
                sram_ub_n = (w_half == HALF_HI) ? !r_be[3] : !r_be[1];
`endif
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign wr_ack      = r_wr_ack;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rd_data = r_rsp_data;

endmodule

// File: tb/tb_sram_width_bridge.sv
// Directed self-checking bench for sram_width_bridge with a behavioural 1K x 16 synchronous SRAM.
module tb_sram_width_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd_en, req_wr_en;
    logic [8:0]  req_addr;
    logic [31:0] req_wr_data;
`ifdef SRAM_BRIDGE_BE_EN
    logic [3:0]  req_be;
`endif
    logic        busy, wr_ack, rsp_valid;
    logic [31:0] rsp_rd_data;
    logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic [9:0]  sram_addr;
    logic [15:0] sram_wr_data, sram_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_width_bridge dut (
        .clk(clk), .rst(rst),
        .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
        .req_addr(req_addr), .req_wr_data(req_wr_data),
`ifdef SRAM_BRIDGE_BE_EN
        .req_be(req_be),
`endif
        .busy(busy), .wr_ack(wr_ack), .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .sram_addr(sram_addr), .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
    );

    // SRAM model: registered read, byte-strobed write.
    logic [15:0] mem [0:1023];
    logic        mem_clr;
    int          wr_cycles = 0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            sram_rd_data <= 16'h0000;
        end else if (!sram_ce_n) begin
            if (!sram_we_n) begin
                if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_wr_data[7:0];
                if (!sram_ub_n) mem[sram_addr][15:8] <= sram_wr_data[15:8];
                wr_cycles <= wr_cycles + 1;
            end
            if (!sram_oe_n) sram_rd_data <= mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts at a negedge with the bridge idle; observes 8 cycles after the acceptance edge.
    task automatic run_txn(input bit is_wr, input bit is_rd, input logic [8:0] addr,
                           input logic [31:0] wd, input bit hold,
                           output int done_n, output int ack_n, output int rsp_n,
                           output int pulse_n, output int a1, output int a2,
                           output logic [31:0] rd);
        done_n = 0; ack_n = 0; rsp_n = 0; pulse_n = 0; a1 = -1; a2 = -1; rd = 'x;
        req_wr_en = is_wr; req_rd_en = is_rd; req_addr = addr; req_wr_data = wd;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) a1 = int'(sram_addr);
            if (n == 2) a2 = int'(sram_addr);
            if (wr_ack) begin ack_n++; pulse_n = n; end
            if (rsp_valid) begin rsp_n++; pulse_n = n; rd = rsp_rd_data; end
            if (!busy && done_n == 0) done_n = n;
            if (!hold || !busy) begin req_wr_en = 1'b0; req_rd_en = 1'b0; end
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs [8];

    int          done_n, ack_n, rsp_n, pulse_n, a1, a2, cnt, wc0;
    logic [31:0] rd;

    initial begin
        vecs[0] = '{1'b1, 9'd5,   32'hDEADBEEF, 32'h0,        16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b0, 9'd5,   32'h0,        32'hDEADBEEF, 16'h0,    16'h0};
        vecs[2] = '{1'b1, 9'd511, 32'h12345678, 32'h0,        16'h5678, 16'h1234};
        vecs[3] = '{1'b0, 9'd511, 32'h0,        32'h12345678, 16'h0,    16'h0};
        vecs[4] = '{1'b0, 9'd0,   32'h0,        32'h00000000, 16'h0,    16'h0};
        vecs[5] = '{1'b1, 9'd0,   32'h0BADF00D, 32'h0,        16'hF00D, 16'h0BAD};
        vecs[6] = '{1'b0, 9'd511, 32'h0,        32'h12345678, 16'h0,    16'h0};
        vecs[7] = '{1'b0, 9'd0,   32'h0,        32'h0BADF00D, 16'h0,    16'h0};

        rst = 1'b1; mem_clr = 1'b1;
        req_rd_en = 1'b0; req_wr_en = 1'b0; req_addr = '0; req_wr_data = '0;
`ifdef SRAM_BRIDGE_BE_EN
        req_be = 4'hF;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);

        check("reset_busy", busy, 0);
        check("reset_wr_ack", wr_ack, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_rd_data, 0);
        check("reset_ctrl", {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("reset_addr", sram_addr, 0);
        check("reset_wdata", sram_wr_data, 0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].is_wr, !vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, 1'b0,
                    done_n, ack_n, rsp_n, pulse_n, a1, a2, rd);
            check($sformatf("v%0d_addr_lo", i), a1, vecs[i].addr * 2);
            check($sformatf("v%0d_addr_hi", i), a2, vecs[i].addr * 2 + 1);
            if (vecs[i].is_wr) begin
                check($sformatf("v%0d_done", i), done_n, 3);
                check($sformatf("v%0d_ack_cnt", i), ack_n, 1);
                check($sformatf("v%0d_rsp_cnt", i), rsp_n, 0);
                check($sformatf("v%0d_ack_pos", i), pulse_n, 3);
                check($sformatf("v%0d_mem_lo", i), mem[{vecs[i].addr, 1'b0}], vecs[i].exp_lo);
                check($sformatf("v%0d_mem_hi", i), mem[{vecs[i].addr, 1'b1}], vecs[i].exp_hi);
                $display("[TB] v%0d write word %0d data 0x%08h", i, vecs[i].addr, vecs[i].wdata);
            end else begin
                check($sformatf("v%0d_done", i), done_n, 4);
                check($sformatf("v%0d_ack_cnt", i), ack_n, 0);
                check($sformatf("v%0d_rsp_cnt", i), rsp_n, 1);
                check($sformatf("v%0d_rsp_pos", i), pulse_n, 4);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
                check($sformatf("v%0d_rdata_hold", i), rsp_rd_data, vecs[i].exp_rd);
                $display("[TB] v%0d read word %0d data 0x%08h", i, vecs[i].addr, rd);
            end
        end

        // Simultaneous read+write with write held through busy: one write only.
        wc0 = wr_cycles;
        run_txn(1'b1, 1'b1, 9'd3, 32'hA5A5A5A5, 1'b1, done_n, ack_n, rsp_n, pulse_n, a1, a2, rd);
        check("both_ack_cnt", ack_n, 1);
        check("both_rsp_cnt", rsp_n, 0);
        check("both_wr_cycles", wr_cycles - wc0, 2);
        check("both_mem_lo", mem[6], 16'hA5A5);
        check("both_mem_hi", mem[7], 16'hA5A5);
        $display("[TB] rd+wr word 3 data 0xA5A5A5A5 acks %0d", ack_n);

        // Reset during ACC_HI of a read.
        req_rd_en = 1'b1; req_addr = 9'd5;
        @(negedge clk); req_rd_en = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("rrd_busy", busy, 0);
        check("rrd_rsp_valid", rsp_valid, 0);
        check("rrd_rsp_data", rsp_rd_data, 0);
        check("rrd_ctrl", {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("rrd_addr", sram_addr, 0);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (rsp_valid || wr_ack) cnt++;
        end
        check("rrd_no_pulse", cnt, 0);
        run_txn(1'b0, 1'b1, 9'd5, 32'h0, 1'b0, done_n, ack_n, rsp_n, pulse_n, a1, a2, rd);
        check("rrd_readback", rd, 32'hDEADBEEF);
        $display("[TB] reset-abort read, then read word 5 data 0x%08h", rd);

        // Reset during ACC_HI of a write: low half lands, high half does not.
        req_wr_en = 1'b1; req_addr = 9'd5; req_wr_data = 32'h11112222;
        @(negedge clk); req_wr_en = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("rwr_ack", wr_ack, 0);
        check("rwr_ctrl", {sram_ce_n, sram_we_n}, 2'b11);
        rst = 1'b0;
        @(negedge clk);
        check("rwr_ack_after", wr_ack, 0);
        check("rwr_mem_lo", mem[10], 16'h2222);
        check("rwr_mem_hi", mem[11], 16'hDEAD);
        run_txn(1'b0, 1'b1, 9'd5, 32'h0, 1'b0, done_n, ack_n, rsp_n, pulse_n, a1, a2, rd);
        check("rwr_readback", rd, 32'hDEAD2222);
        $display("[TB] reset-abort write, then read word 5 data 0x%08h", rd);

`ifdef SRAM_BRIDGE_BE_EN
        req_be = 4'hF;
        run_txn(1'b1, 1'b0, 9'd8, 32'h00000000, 1'b0, done_n, ack_n, rsp_n, pulse_n, a1, a2, rd);
        req_be = 4'b0101;
        run_txn(1'b1, 1'b0, 9'd8, 32'hFFFFFFFF, 1'b0, done_n, ack_n, rsp_n, pulse_n, a1, a2, rd);
        check("be_ack", ack_n, 1);
        check("be_mem_lo", mem[16], 16'h00FF);
        check("be_mem_hi", mem[17], 16'h00FF);
        req_be = 4'b0000;
        run_txn(1'b0, 1'b1, 9'd8, 32'h0, 1'b0, done_n, ack_n, rsp_n, pulse_n, a1, a2, rd);
        check("be_readback", rd, 32'h00FF00FF);
        $display("[TB] byte-enable write word 8 be 0101 read 0x%08h", rd);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
